// File: rtl/mult8_seq_ctrl.sv
// Sequencing controller for an unsigned 8x8 multiply. It drives a shared
// combinational 4x4 multiplier four times and accumulates the shifted partial
// products into a 16-bit result. The requester and the consumer each use a
// valid/ready handshake.
module mult8_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product,
    output logic [3:0]  mul_m,
    output logic [3:0]  mul_q,
    input  logic [7:0]  mul_p
);

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  step_q, step_d;
    logic [15:0] acc_q, acc_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [15:0] pp_ext;
    logic [15:0] pp_shifted;

    // Partial products are zero-extended before shifting; the worst-case total
    // (0xFE01) fits in 16 bits, so no carry-out is kept.
    assign pp_ext  = {8'h00, mul_p};
    assign product = acc_q;

    // State, step counter, accumulator and operand registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            step_q  <= 2'd0;
            acc_q   <= 16'h0000;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    // Next-state, operand slice muxing, accumulation and handshake outputs.
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        acc_d      = acc_q;
        a_d        = a_q;
        b_d        = b_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        mul_m      = 4'h0;
        mul_q      = 4'h0;
        pp_shifted = 16'h0000;

        case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = 16'h0000;
                    step_d  = 2'd0;
                    state_d = StMul;
                end
            end

            StMul: begin
                unique case (step_q)
                    2'd0: begin
                        mul_m      = a_q[3:0];
                        mul_q      = b_q[3:0];
                        pp_shifted = pp_ext;
                    end
                    2'd1: begin
                        mul_m      = a_q[7:4];
                        mul_q      = b_q[3:0];
                        pp_shifted = pp_ext << 4;
                    end
                    2'd2: begin
                        mul_m      = a_q[3:0];
                        mul_q      = b_q[7:4];
                        pp_shifted = pp_ext << 4;
                    end
                    2'd3: begin
                        mul_m      = a_q[7:4];
                        mul_q      = b_q[7:4];
                        pp_shifted = pp_ext << 8;
                    end
                endcase
                acc_d  = acc_q + pp_shifted;
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) begin
                    state_d = StDone;
                end
            end

            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Self-checking bench for mult8_seq_ctrl. The shared 4x4 multiplier is
// modelled here as a plain combinational product; expected results come
// straight from a*b and from the slice order each step should present.
module tb_mult8_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic [3:0]  mul_m;
    logic [3:0]  mul_q;
    logic [7:0]  mul_p;

    int errors;
    int checks;
    int cyc;

    mult8_seq_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .product  (product),
        .mul_m    (mul_m),
        .mul_q    (mul_q),
        .mul_p    (mul_p)
    );

    // External 4x4 multiplier.
    assign mul_p = mul_m * mul_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slice order each step must present, packed {m,q} per step, step 0 lowest.
    function automatic logic [31:0] exp_trace(input logic [7:0] ea, input logic [7:0] eb);
        return {ea[7:4], eb[7:4], ea[3:0], eb[7:4], ea[7:4], eb[3:0], ea[3:0], eb[3:0]};
    endfunction

    // Drive one request and observe it up to the first DONE cycle (T+5).
    // Returns with the bench positioned 1 time unit after the edge ending T+4.
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input bit hold,
                          output logic [31:0] trace, output logic [15:0] res,
                          output logic ov5, output logic early, output logic ok,
                          output int acc_cyc);
        int waited;
        ok      = 1'b0;
        trace   = 32'h0;
        res     = 16'h0;
        ov5     = 1'b0;
        early   = 1'b0;
        acc_cyc = 0;
        in_valid = 1'b1;
        a = ia;
        b = ib;
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (in_ready) begin
            ok = 1'b1;
            @(posedge clk);
            #1;
            acc_cyc = cyc;
            if (!hold) in_valid = 1'b0;
            a = 8'($urandom);
            b = 8'($urandom);
            for (int s = 0; s < 4; s++) begin
                trace[s*8 +: 8] = {mul_m, mul_q};
                if (out_valid || in_ready) early = 1'b1;
                @(posedge clk);
                #1;
            end
            ov5 = out_valid;
            res = product;
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        checks++;
        if (product !== 16'h0000) begin
            errors++;
            $display("FAIL reset_product: got %h want 0000", product);
        end
        checks++;
        if (mul_m !== 4'h0 || mul_q !== 4'h0) begin
            errors++;
            $display("FAIL reset_mul_ops: got m=%h q=%h want 0/0", mul_m, mul_q);
        end
    endtask

    task automatic test_single();
        logic [31:0] tr;
        logic [15:0] res;
        logic ov5, early, ok;
        int ac;
        out_ready = 1'b1;
        run_op(8'h12, 8'h34, 1'b0, tr, res, ov5, early, ok, ac);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_accept: in_ready never rose");
        end
        checks++;
        if (tr !== exp_trace(8'h12, 8'h34)) begin
            errors++;
            $display("FAIL single_trace: got %h want %h", tr, exp_trace(8'h12, 8'h34));
        end
        checks++;
        if (ov5 !== 1'b1 || early !== 1'b0) begin
            errors++;
            $display("FAIL single_latency: got ov5=%b early=%b want 1/0", ov5, early);
        end
        checks++;
        if (res !== 16'h03A8) begin
            errors++;
            $display("FAIL single_product: got %h want 03a8", res);
        end
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || mul_m !== 4'h0 || mul_q !== 4'h0) begin
            errors++;
            $display("FAIL single_after_hs: got rdy=%b ov=%b m=%h q=%h want 1/0/0/0",
                     in_ready, out_valid, mul_m, mul_q);
        end
        checks++;
        if (product !== 16'h03A8) begin
            errors++;
            $display("FAIL single_product_hold: got %h want 03a8", product);
        end
    endtask

    task automatic test_corners();
        logic [7:0] ta [8];
        logic [7:0] tb_ [8];
        logic [31:0] tr;
        logic [15:0] res;
        logic ov5, early, ok;
        int ac;
        ta[0] = 8'hFF; tb_[0] = 8'hFF;
        ta[1] = 8'h00; tb_[1] = 8'hA7;
        ta[2] = 8'hA5; tb_[2] = 8'h5A;
        ta[3] = 8'h80; tb_[3] = 8'h02;
        for (int i = 4; i < 8; i++) begin
            ta[i]  = 8'($urandom);
            tb_[i] = 8'($urandom);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            run_op(ta[i], tb_[i], 1'b0, tr, res, ov5, early, ok, ac);
            checks++;
            if (!ok || ov5 !== 1'b1 || early !== 1'b0 || res !== 16'(ta[i] * tb_[i])
                || tr !== exp_trace(ta[i], tb_[i])) begin
                errors++;
                $display("FAIL corner_%0d: %h*%h got ok=%b ov5=%b early=%b p=%h tr=%h want p=%h tr=%h",
                         i, ta[i], tb_[i], ok, ov5, early, res, tr,
                         16'(ta[i] * tb_[i]), exp_trace(ta[i], tb_[i]));
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] tr;
        logic [15:0] res;
        logic ov5, early, ok;
        int ac;
        int bad;
        logic [7:0] ra, rb;
        out_ready = 1'b0;
        run_op(8'h0F, 8'h11, 1'b0, tr, res, ov5, early, ok, ac);
        checks++;
        if (!ok || ov5 !== 1'b1 || res !== 16'h00FF) begin
            errors++;
            $display("FAIL bp_product: got ok=%b ov=%b p=%h want 1/1/00ff", ok, ov5, res);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a = 8'h55;
            b = 8'h66;
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || product !== 16'h00FF || in_ready !== 1'b0
                || mul_m !== 4'h0 || mul_q !== 4'h0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_stall_hold: got %0d bad stall cycles want 0 (last ov=%b p=%h rdy=%b)",
                     bad, out_valid, product, in_ready);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got rdy=%b ov=%b want 1/0", in_ready, out_valid);
        end
        ra = 8'($urandom);
        rb = 8'($urandom);
        run_op(ra, rb, 1'b0, tr, res, ov5, early, ok, ac);
        checks++;
        if (!ok || ov5 !== 1'b1 || res !== 16'(ra * rb)) begin
            errors++;
            $display("FAIL bp_next_op: got p=%h want %h", res, 16'(ra * rb));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] tr;
        logic [15:0] res;
        logic ov5, early, ok;
        int ac;
        int rises;
        out_ready = 1'b1;
        in_valid = 1'b1;
        a = 8'hFF;
        b = 8'hFF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 16'h0000) begin
            errors++;
            $display("FAIL rstmid_state: got rdy=%b ov=%b p=%h want 1/0/0000",
                     in_ready, out_valid, product);
        end
        rises = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) rises++;
        end
        checks++;
        if (rises != 0) begin
            errors++;
            $display("FAIL rstmid_no_valid: got %0d valid cycles want 0", rises);
        end
        run_op(8'h03, 8'h05, 1'b0, tr, res, ov5, early, ok, ac);
        checks++;
        if (!ok || ov5 !== 1'b1 || res !== 16'h000F) begin
            errors++;
            $display("FAIL rstmid_next: got ok=%b ov=%b p=%h want 1/1/000f", ok, ov5, res);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] ta [3];
        logic [7:0] tb_ [3];
        logic [15:0] want [3];
        logic [31:0] tr;
        logic [15:0] res;
        logic ov5, early, ok;
        int ac;
        int prev;
        ta[0] = 8'h10; tb_[0] = 8'h10; want[0] = 16'h0100;
        ta[1] = 8'h07; tb_[1] = 8'h09; want[1] = 16'h003F;
        ta[2] = 8'hFF; tb_[2] = 8'h01; want[2] = 16'h00FF;
        out_ready = 1'b1;
        prev = 0;
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tb_[i], 1'b1, tr, res, ov5, early, ok, ac);
            checks++;
            if (!ok || ov5 !== 1'b1 || early !== 1'b0 || res !== want[i]) begin
                errors++;
                $display("FAIL b2b_result_%0d: got ok=%b ov=%b p=%h want 1/1/%h",
                         i, ok, ov5, res, want[i]);
            end
            if (i > 0) begin
                checks++;
                if (ac - prev != 6) begin
                    errors++;
                    $display("FAIL b2b_spacing_%0d: got %0d cycles want 6", i, ac - prev);
                end
            end
            prev = ac;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_random_stall();
        logic [31:0] tr;
        logic [15:0] res;
        logic ov5, early, ok;
        int ac;
        logic [7:0] ra, rb;
        int bad;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            out_ready = 1'b0;
            run_op(ra, rb, 1'b0, tr, res, ov5, early, ok, ac);
            if (!ok || ov5 !== 1'b1 || res !== 16'(ra * rb) || tr !== exp_trace(ra, rb)) bad++;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
                if (out_valid !== 1'b1 || product !== 16'(ra * rb)) bad++;
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL random_stall: got %0d bad observations want 0", bad);
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_corners();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
